// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM built-in self test.
// Holds the FSM state set, the default seed and the test pattern.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        FLUSH,
        DONE
    } state_e;

    localparam logic [7:0] SEED_DEFAULT = 8'hA5;

    // Pass 1 writes the complement so every cell sees both polarities.
    function automatic logic [63:0] pattern(
        input logic [63:0] addr,
        input logic [63:0] seed,
        input logic        pass
    );
        return pass ? ~(addr ^ seed) : (addr ^ seed);
    endfunction

endpackage

// File: rtl/ram_bist.sv
// Two-pass write/read-back self test for a synchronous single-clock RAM.
// Stops at the first mismatch and reports address, expected and read data.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int                 D_WIDTH = 8,
    parameter int                 A_WIDTH = 5,
    parameter int                 A_MAX   = 32,
    parameter logic [D_WIDTH-1:0] SEED    = D_WIDTH'(SEED_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [A_WIDTH-1:0] fail_address,
    output logic [D_WIDTH-1:0] fail_expected,
    output logic [D_WIDTH-1:0] fail_actual,
    output logic [A_WIDTH-1:0] address_write,
    output logic [D_WIDTH-1:0] data_write,
    output logic               write_enable,
    output logic [A_WIDTH-1:0] address_read,
    input  logic [D_WIDTH-1:0] data_read
);

    localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(A_MAX - 1);

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] cnt_q, cnt_d;
    logic               pass_q, pass_d;
    logic               rd_vld_q, rd_vld_d;
    logic [A_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [A_WIDTH-1:0] fail_address_q, fail_address_d;
    logic [D_WIDTH-1:0] fail_expected_q, fail_expected_d;
    logic [D_WIDTH-1:0] fail_actual_q, fail_actual_d;
    logic               we_q, we_d;
    logic [A_WIDTH-1:0] aw_q, aw_d;
    logic [D_WIDTH-1:0] dw_q, dw_d;
    logic [A_WIDTH-1:0] ar_q, ar_d;
    logic [D_WIDTH-1:0] rd_expected;
    logic               mismatch;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pass_d          = pass_q;
        error_d         = error_q;
        fail_address_d  = fail_address_q;
        fail_expected_d = fail_expected_q;
        fail_actual_d   = fail_actual_q;
        rd_vld_d        = (state_q == READ);
        rd_addr_d       = cnt_q;
        rd_expected     = D_WIDTH'(pattern(64'(rd_addr_q), 64'(SEED), pass_q));
        mismatch        = rd_vld_q && (data_read != rd_expected)
                          && (state_q == READ || state_q == FLUSH);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d         = WRITE;
                    cnt_d           = '0;
                    pass_d          = 1'b0;
                    error_d         = 1'b0;
                    fail_address_d  = '0;
                    fail_expected_d = '0;
                    fail_actual_d   = '0;
                end
            end
            WRITE: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q + A_WIDTH'(1);
                end
            end
            READ: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + A_WIDTH'(1);
                end
            end
            FLUSH: begin
                if (!pass_q) begin
                    state_d = WRITE;
                    pass_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The last read of a pass is still compared during FLUSH.
        if (mismatch) begin
            state_d         = DONE;
            error_d         = 1'b1;
            fail_address_d  = rd_addr_q;
            fail_expected_d = rd_expected;
            fail_actual_d   = data_read;
        end

        we_d   = (state_d == WRITE);
        aw_d   = we_d ? cnt_d : aw_q;
        dw_d   = we_d ? D_WIDTH'(pattern(64'(cnt_d), 64'(SEED), pass_d)) : dw_q;
        ar_d   = (state_d == READ) ? cnt_d : ar_q;
        busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == FLUSH);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            pass_q          <= 1'b0;
            rd_vld_q        <= 1'b0;
            rd_addr_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            fail_address_q  <= '0;
            fail_expected_q <= '0;
            fail_actual_q   <= '0;
            we_q            <= 1'b0;
            aw_q            <= '0;
            dw_q            <= '0;
            ar_q            <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pass_q          <= pass_d;
            rd_vld_q        <= rd_vld_d;
            rd_addr_q       <= rd_addr_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            fail_address_q  <= fail_address_d;
            fail_expected_q <= fail_expected_d;
            fail_actual_q   <= fail_actual_d;
            we_q            <= we_d;
            aw_q            <= aw_d;
            dw_q            <= dw_d;
            ar_q            <= ar_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign fail_address  = fail_address_q;
    assign fail_expected = fail_expected_q;
    assign fail_actual   = fail_actual_q;
    assign write_enable  = we_q;
    assign address_write = aw_q;
    assign data_write    = dw_q;
    assign address_read  = ar_q;

endmodule
